ahb_modport: RTL and testbench
==============================

AHB_MODPORT -- requirements
Module: ahb_modport

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, number of 32-bit memory words (power of two, 4..256).
REQ-002 SHALL have ports: HCLK  in  1  clock; one clock only, all logic on rising edge.
REQ-003 SHALL have ports: HRESET  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: HTRANS in 2 (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ); HBURST in 3 (0 SINGLE, 1 INCR, 2 WRAP4, 3 INCR4, 4 WRAP8, 5 INCR8, 6 WRAP16, 7 INCR16); HSIZE in 3; HWRITE in 1; HADDR in 32; HWDATA in 32.
REQ-005 SHALL have ports: HREADY out 1 transfer done; HRESP out 2 (0 OKAY, 1 ERROR); HRDATA out 32 read data.
REQ-006 SHALL have, only with AHB_MODPORT_CHK_EN, ports PROT_ERR out 1 (one-cycle pulse) and PROT_CODE out 3 (violation code).

Function
REQ-007 SHALL accept an address phase on a rising edge with HREADY=1 and HTRANS NONSEQ or SEQ; the data phase is the following cycle(s).
REQ-008 SHALL answer IDLE, BUSY and no-transfer cycles with HRESP=OKAY, HREADY=1, zero wait states.
REQ-009 SHALL give an ERROR response when the accepted transfer is illegal: HSIZE>2; HSIZE=1 with HADDR[0]=1; HSIZE=2 with HADDR[1:0]!=0; or word index HADDR[31:2] >= MEM_WORDS.
REQ-010 An ERROR response SHALL take two cycles: cycle 1 HRESP=1 and HREADY=0; cycle 2 HRESP=1 and HREADY=1. Memory SHALL NOT change, and HRDATA SHALL be 0.
REQ-011 Legal transfers SHALL finish with zero wait states: HRESP=0 and HREADY=1 in the data phase.
REQ-012 Writes SHALL update memory at the end of the data phase from HWDATA. Byte lanes come from HSIZE and HADDR[1:0], little-endian (byte n = HWDATA[8n+7:8n]).
REQ-013 Reads SHALL present the full 32-bit word mem[HADDR[9:2]] on HRDATA in the data phase. HRDATA SHALL be 0 in any other cycle.
REQ-014 When a read address phase targets the word being written in the current data phase, HRDATA SHALL return the newly merged word (write-to-read forwarding).
REQ-015 An address phase that arrives during ERROR cycle 1 (HREADY=0) SHALL be ignored. An address phase in ERROR cycle 2 SHALL be accepted normally.

Reset
REQ-016 While HRESET=1 at a rising edge: HREADY=1, HRESP=0, HRDATA=0, pending data phase discarded (no write), checker history cleared, PROT_ERR=0, PROT_CODE=0.
REQ-017 Memory contents SHALL NOT be reset. Reset during an ERROR response SHALL abort it immediately.

Configuration
REQ-018 Macro AHB_MODPORT_CHK_EN defined: the protocol checker is instantiated and PROT_ERR/PROT_CODE exist. It SHALL pulse PROT_ERR for the cycle after a violation, with PROT_CODE set to:
- 1: second ERROR cycle with HTRANS!=IDLE.
- 2: BUSY while HBURST=SINGLE.
- 3: INCR-type SEQ address != previous address + 2**HSIZE.
- 4: WRAP-type SEQ address not the wrapped increment within a (beats*2**HSIZE)-byte block.
- 5: SEQ with HADDR[9:0]=0 (1KB boundary crossed).
The lowest code wins if several apply. The previous address used for codes 3/4 SHALL update only on accepted NONSEQ/SEQ.
REQ-019 Macro undefined: no checker logic and no PROT_* ports. Slave behaviour SHALL be identical in both cases.

Structure
REQ-020 Package ahb_modport_pkg SHALL hold the HTRANS, HBURST, HSIZE and HRESP enums, the PROT_CODE enum, and the constant MAX_WORDS=256.
REQ-021 The checker SHALL be the sub-module ahb_modport_chk. The slave datapath, memory and response FSM (states OKAY, ERR1, ERR2) stay in ahb_modport.

Verification
REQ-022 Write NONSEQ word 0x10 with data 0xDEADBEEF, then read 0x10 -> HRDATA=0xDEADBEEF, HRESP=0, HREADY=1 throughout.
REQ-023 Byte write 0xAA to 0x13 over word 0x11223344, then read 0x10 -> 0xAA223344.
REQ-024 Word transfer to 0x02 -> HREADY=0/HRESP=1, then HREADY=1/HRESP=1; memory unchanged.
REQ-025 Write 0x55 to 0x20 followed back-to-back by a read of 0x20 -> read returns 0x55 (forwarding).
REQ-026 With AHB_MODPORT_CHK_EN, INCR4 word burst at 0x100 whose second beat is 0x108 -> PROT_ERR=1, PROT_CODE=3 for one cycle.
REQ-027 HRESET asserted in ERROR cycle 1 -> next cycle HREADY=1, HRESP=0, no write performed.

Source files
------------

// File: rtl/ahb_modport_pkg.sv
// Shared AHB encodings, checker violation codes and the byte-lane helper
// used by the ahb_modport slave and its optional protocol checker.
package ahb_modport_pkg;

  localparam int MAX_WORDS = 256;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1
  } hresp_e;

  typedef enum logic [2:0] {
    PROT_NONE        = 3'd0,
    PROT_ERR2_ACTIVE = 3'd1,
    PROT_BUSY_SINGLE = 3'd2,
    PROT_INCR_ADDR   = 3'd3,
    PROT_WRAP_ADDR   = 3'd4,
    PROT_KB_CROSS    = 3'd5
  } prot_code_e;

  // Little-endian byte lanes touched by a transfer of the given size.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      3'd0:    lane_mask = 4'b0001 << addr_lo;
      3'd1:    lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_modport_chk.sv
// Optional AHB protocol checker: flags master-side violations as a one-cycle
// PROT_ERR pulse with a code; the lowest applicable code is reported.
module ahb_modport_chk
  import ahb_modport_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hburst,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic        hready,
  input  logic [1:0]  hresp,
  output logic        prot_err,
  output logic [2:0]  prot_code
);

  logic [31:0] prev_addr;
  logic [31:0] step;
  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;
  logic [31:0] wrap_addr;
  logic        is_seq;
  logic        is_wrap;
  logic        is_incr;
  prot_code_e  code;

  always_comb begin
    step      = 32'd1 << hsize;
    incr_addr = prev_addr + step;
    case (hburst)
      HBURST_WRAP4:  wrap_mask = (step << 2) - 32'd1;
      HBURST_WRAP8:  wrap_mask = (step << 3) - 32'd1;
      HBURST_WRAP16: wrap_mask = (step << 4) - 32'd1;
      default:       wrap_mask = '0;
    endcase
    wrap_addr = (prev_addr & ~wrap_mask) | (incr_addr & wrap_mask);
    is_seq    = hready && (htrans == HTRANS_SEQ);
    is_wrap   = (hburst == HBURST_WRAP4) || (hburst == HBURST_WRAP8) || (hburst == HBURST_WRAP16);
    is_incr   = (hburst == HBURST_INCR) || (hburst == HBURST_INCR4) ||
                (hburst == HBURST_INCR8) || (hburst == HBURST_INCR16);

    // Second error cycle is the only one where HREADY=1 and HRESP=ERROR.
    code = PROT_NONE;
    if (hready && (hresp == HRESP_ERROR) && (htrans != HTRANS_IDLE))
      code = PROT_ERR2_ACTIVE;
    else if ((htrans == HTRANS_BUSY) && (hburst == HBURST_SINGLE))
      code = PROT_BUSY_SINGLE;
    else if (is_seq && is_incr && (haddr != incr_addr))
      code = PROT_INCR_ADDR;
    else if (is_seq && is_wrap && (haddr != wrap_addr))
      code = PROT_WRAP_ADDR;
    else if (is_seq && (haddr[9:0] == 10'd0))
      code = PROT_KB_CROSS;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_addr <= '0;
      prot_err  <= 1'b0;
      prot_code <= 3'd0;
    end else begin
      prot_err  <= (code != PROT_NONE);
      prot_code <= code;
      if (hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ)))
        prev_addr <= haddr;
    end
  end

endmodule

// File: rtl/ahb_modport.sv
// Zero-wait-state AHB memory slave with two-cycle ERROR responses and
// write-to-read forwarding. Define AHB_MODPORT_CHK_EN to add the protocol checker.
module ahb_modport
  import ahb_modport_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
`ifdef AHB_MODPORT_CHK_EN
  ,
  output logic        PROT_ERR,
  output logic [2:0]  PROT_CODE
`endif
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {OKAY, ERR1, ERR2} resp_state_e;

  resp_state_e      state;
  logic [31:0]      mem [MEM_WORDS];
  logic             wr_pend;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_lanes;
  logic             accept;
  logic             illegal;
  logic [IDX_W-1:0] addr_idx;
  logic [31:0]      merged;

  assign accept   = HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign addr_idx = HADDR[IDX_W+1:2];

  always_comb begin
    illegal = 1'b0;
    if (HSIZE > 3'd2)
      illegal = 1'b1;
    else if ((HSIZE == 3'd1) && HADDR[0])
      illegal = 1'b1;
    else if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'd0))
      illegal = 1'b1;
    if (HADDR[31:2] >= 30'(MEM_WORDS))
      illegal = 1'b1;
  end

  // The word as it will look once the pending write lands; also used for forwarding.
  always_comb begin
    merged = mem[wr_idx];
    for (int b = 0; b < 4; b++)
      if (wr_lanes[b])
        merged[8*b +: 8] = HWDATA[8*b +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && wr_pend)
      mem[wr_idx] <= merged;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= OKAY;
      HREADY   <= 1'b1;
      HRESP    <= HRESP_OKAY;
      HRDATA   <= '0;
      wr_pend  <= 1'b0;
      wr_idx   <= '0;
      wr_lanes <= '0;
    end else begin
      state   <= OKAY;
      HREADY  <= 1'b1;
      HRESP   <= HRESP_OKAY;
      HRDATA  <= '0;
      wr_pend <= 1'b0;
      if (state == ERR1) begin
        state  <= ERR2;
        HRESP  <= HRESP_ERROR;
      end else if (accept) begin
        if (illegal) begin
          state  <= ERR1;
          HREADY <= 1'b0;
          HRESP  <= HRESP_ERROR;
        end else if (HWRITE) begin
          wr_pend  <= 1'b1;
          wr_idx   <= addr_idx;
          wr_lanes <= lane_mask(HSIZE, HADDR[1:0]);
        end else begin
          HRDATA <= (wr_pend && (wr_idx == addr_idx)) ? merged : mem[addr_idx];
        end
      end
    end
  end

`ifdef AHB_MODPORT_CHK_EN
  ahb_modport_chk u_chk (
    .clk       (HCLK),
    .reset     (HRESET),
    .htrans    (HTRANS),
    .hburst    (HBURST),
    .hsize     (HSIZE),
    .haddr     (HADDR),
    .hready    (HREADY),
    .hresp     (HRESP),
    .prot_err  (PROT_ERR),
    .prot_code (PROT_CODE)
  );
`else
  logic unused_burst;
  assign unused_burst = ^HBURST;
`endif

endmodule

// File: tb/tb_ahb_modport.sv
// Directed self-checking bench for ahb_modport; checker vectors run only
// when AHB_MODPORT_CHK_EN is defined.
module tb_ahb_modport;
  import ahb_modport_pkg::*;

  logic        hclk;
  logic        hreset;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
`ifdef AHB_MODPORT_CHK_EN
  logic        prot_err;
  logic [2:0]  prot_code;
`endif

  int check_count = 0;
  int error_count = 0;

  ahb_modport #(.MEM_WORDS(256)) dut (
    .HCLK      (hclk),
    .HRESET    (hreset),
    .HTRANS    (htrans),
    .HBURST    (hburst),
    .HSIZE     (hsize),
    .HWRITE    (hwrite),
    .HADDR     (haddr),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HRESP     (hresp),
    .HRDATA    (hrdata)
`ifdef AHB_MODPORT_CHK_EN
    ,
    .PROT_ERR  (prot_err),
    .PROT_CODE (prot_code)
`endif
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one bus cycle; hwdata belongs to the transfer whose address came a cycle earlier.
  task automatic applyStimulus(input logic [1:0] trans, input logic [2:0] burst, input logic [2:0] size,
                               input logic write, input logic [31:0] addr, input logic [31:0] wdata);
    htrans = trans;
    hburst = burst;
    hsize  = size;
    hwrite = write;
    haddr  = addr;
    hwdata = wdata;
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_cycle(input logic [31:0] wdata);
    applyStimulus(HTRANS_IDLE, HBURST_SINGLE, HSIZE_WORD, 1'b0, 32'h0, wdata);
  endtask

  task automatic single(input logic write, input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    applyStimulus(HTRANS_NONSEQ, HBURST_SINGLE, size, write, addr, wdata);
  endtask

  initial begin
    hreset = 1'b1;
    idle_cycle(32'h0);
    idle_cycle(32'h0);
    checkOutput("reset_hready", {31'd0, hready}, 32'd1);
    checkOutput("reset_hresp", {30'd0, hresp}, 32'd0);
    checkOutput("reset_hrdata", hrdata, 32'd0);
`ifdef AHB_MODPORT_CHK_EN
    checkOutput("reset_prot", {28'd0, prot_err, prot_code}, 32'd0);
`endif
    hreset = 1'b0;

    // Plain word write then read
    single(1'b1, HSIZE_WORD, 32'h10, 32'h0);
    checkOutput("wr_hready", {31'd0, hready}, 32'd1);
    checkOutput("wr_hresp", {30'd0, hresp}, 32'd0);
    idle_cycle(32'hDEADBEEF);
    single(1'b0, HSIZE_WORD, 32'h10, 32'h0);
    checkOutput("rd_data", hrdata, 32'hDEADBEEF);
    checkOutput("rd_hready", {31'd0, hready}, 32'd1);
    checkOutput("rd_hresp", {30'd0, hresp}, 32'd0);
    idle_cycle(32'h0);
    checkOutput("idle_hrdata", hrdata, 32'd0);

    // Byte merge into lane 3
    single(1'b1, HSIZE_WORD, 32'h10, 32'h0);
    idle_cycle(32'h11223344);
    single(1'b1, HSIZE_BYTE, 32'h13, 32'h0);
    idle_cycle(32'hAA000000);
    single(1'b0, HSIZE_WORD, 32'h10, 32'h0);
    checkOutput("byte_merge", hrdata, 32'hAA223344);
    idle_cycle(32'h0);

    // Misaligned word: two-cycle error, address phase in ERR1 ignored
    single(1'b1, HSIZE_WORD, 32'h0, 32'h0);
    idle_cycle(32'hCAFEF00D);
    single(1'b1, HSIZE_WORD, 32'h2, 32'h0);
    checkOutput("err1_hready", {31'd0, hready}, 32'd0);
    checkOutput("err1_hresp", {30'd0, hresp}, 32'd1);
    checkOutput("err1_hrdata", hrdata, 32'd0);
    single(1'b1, HSIZE_WORD, 32'h0, 32'h0BADBAD0);
    checkOutput("err2_hready", {31'd0, hready}, 32'd1);
    checkOutput("err2_hresp", {30'd0, hresp}, 32'd1);
    idle_cycle(32'hFFFFFFFF);
    checkOutput("post_err_hresp", {30'd0, hresp}, 32'd0);
    single(1'b0, HSIZE_WORD, 32'h0, 32'h0);
    checkOutput("err_mem_kept", hrdata, 32'hCAFEF00D);
    idle_cycle(32'h0);

    // Bad size, then a read accepted during ERR2
    single(1'b0, 3'd3, 32'h10, 32'h0);
    checkOutput("size_err_hresp", {30'd0, hresp}, 32'd1);
    idle_cycle(32'h0);
    single(1'b0, HSIZE_WORD, 32'h10, 32'h0);
    checkOutput("err2_accept_data", hrdata, 32'hAA223344);
    checkOutput("err2_accept_hresp", {30'd0, hresp}, 32'd0);
`ifdef AHB_MODPORT_CHK_EN
    checkOutput("prot_code1", {28'd0, prot_err, prot_code}, {28'd0, 1'b1, 3'd1});
`endif
    idle_cycle(32'h0);

    // Out-of-range word index and odd halfword
    single(1'b0, HSIZE_WORD, 32'h400, 32'h0);
    checkOutput("range_err_hready", {31'd0, hready}, 32'd0);
    idle_cycle(32'h0);
    idle_cycle(32'h0);
    single(1'b0, HSIZE_HALF, 32'h11, 32'h0);
    checkOutput("half_odd_hresp", {30'd0, hresp}, 32'd1);
    idle_cycle(32'h0);
    idle_cycle(32'h0);

    // Back-to-back forwarding, word then halfword
    single(1'b1, HSIZE_WORD, 32'h20, 32'h0);
    single(1'b0, HSIZE_WORD, 32'h20, 32'h00000055);
    checkOutput("fwd_word", hrdata, 32'h00000055);
    single(1'b1, HSIZE_HALF, 32'h22, 32'h0);
    single(1'b0, HSIZE_WORD, 32'h20, 32'hBEEF0000);
    checkOutput("fwd_half", hrdata, 32'hBEEF0055);
    idle_cycle(32'h0);

    applyStimulus(HTRANS_BUSY, HBURST_INCR, HSIZE_WORD, 1'b0, 32'h30, 32'h0);
    checkOutput("busy_okay", {hrdata[29:0], hready, hresp[0]}, 32'h2);
    idle_cycle(32'h0);

`ifdef AHB_MODPORT_CHK_EN
    applyStimulus(HTRANS_NONSEQ, HBURST_INCR4, HSIZE_WORD, 1'b0, 32'h100, 32'h0);
    applyStimulus(HTRANS_SEQ, HBURST_INCR4, HSIZE_WORD, 1'b0, 32'h104, 32'h0);
    checkOutput("incr_ok", {31'd0, prot_err}, 32'd0);
    applyStimulus(HTRANS_NONSEQ, HBURST_INCR4, HSIZE_WORD, 1'b0, 32'h100, 32'h0);
    applyStimulus(HTRANS_SEQ, HBURST_INCR4, HSIZE_WORD, 1'b0, 32'h108, 32'h0);
    checkOutput("prot_code3", {28'd0, prot_err, prot_code}, {28'd0, 1'b1, 3'd3});
    idle_cycle(32'h0);
    checkOutput("prot_pulse_end", {31'd0, prot_err}, 32'd0);
    applyStimulus(HTRANS_BUSY, HBURST_SINGLE, HSIZE_WORD, 1'b0, 32'h0, 32'h0);
    checkOutput("prot_code2", {28'd0, prot_err, prot_code}, {28'd0, 1'b1, 3'd2});
    applyStimulus(HTRANS_NONSEQ, HBURST_WRAP4, HSIZE_WORD, 1'b0, 32'h10C, 32'h0);
    applyStimulus(HTRANS_SEQ, HBURST_WRAP4, HSIZE_WORD, 1'b0, 32'h100, 32'h0);
    checkOutput("wrap_ok", {31'd0, prot_err}, 32'd0);
    applyStimulus(HTRANS_SEQ, HBURST_WRAP4, HSIZE_WORD, 1'b0, 32'h110, 32'h0);
    checkOutput("prot_code4", {28'd0, prot_err, prot_code}, {28'd0, 1'b1, 3'd4});
    idle_cycle(32'h0);
    applyStimulus(HTRANS_NONSEQ, HBURST_INCR, HSIZE_WORD, 1'b0, 32'h3FC, 32'h0);
    applyStimulus(HTRANS_SEQ, HBURST_INCR, HSIZE_WORD, 1'b0, 32'h400, 32'h0);
    checkOutput("prot_code5", {28'd0, prot_err, prot_code}, {28'd0, 1'b1, 3'd5});
    idle_cycle(32'h0);
    idle_cycle(32'h0);
`endif

    // Reset during ERR1 aborts the error response
    single(1'b1, HSIZE_WORD, 32'h2, 32'h0);
    hreset = 1'b1;
    idle_cycle(32'h0);
    checkOutput("rst_err_hready", {31'd0, hready}, 32'd1);
    checkOutput("rst_err_hresp", {30'd0, hresp}, 32'd0);
    hreset = 1'b0;

    // Reset discards a pending write data phase
    single(1'b1, HSIZE_WORD, 32'h0, 32'h0);
    hreset = 1'b1;
    idle_cycle(32'h11111111);
    hreset = 1'b0;
    single(1'b0, HSIZE_WORD, 32'h0, 32'h0);
    checkOutput("rst_no_write", hrdata, 32'hCAFEF00D);
    idle_cycle(32'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
